// File: rtl/motor_move_sequencer.sv
// Move sequencer for the stepper motor controller: paces ENABLE strobes for one
// commanded move, tracks absolute position in half steps and reports DONE/ABORTED.
module motor_move_sequencer #(
   parameter int CNT_W         = 16,
   parameter int DIV_W         = 16,
   parameter int POS_W         = 24,
   parameter int SETTLE_CYCLES = 4
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             START,
   input  logic             ABORT,
   input  logic [CNT_W-1:0] STEPS,
   input  logic             DIR,
   input  logic             HALF,
   input  logic [DIV_W-1:0] PERIOD,
   output logic             ENABLE,
   output logic             UP_DOWN,
   output logic             HALF_FULL,
   output logic             BUSY,
   output logic             DONE,
   output logic             ABORTED,
   output logic [CNT_W-1:0] STEPS_LEFT,
   output logic [POS_W-1:0] POSITION
);

   localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

   typedef enum logic [1:0] {IDLE, RUN, SETTLE} state_t;

   state_t                  state, state_nx;
   logic [DIV_W-1:0]        period_q, period_nx;
   logic [DIV_W-1:0]        div_q, div_nx;
   logic [SET_W-1:0]        settle_q, settle_nx;
   logic [CNT_W-1:0]        steps_q, steps_nx;
   logic signed [POS_W-1:0] pos_q, pos_nx;
   logic                    enable_q, enable_nx;
   logic                    up_q, up_nx;
   logic                    half_q, half_nx;
   logic                    busy_q, busy_nx;
   logic                    done_q, done_nx;
   logic                    aborted_q, aborted_nx;

   // Signed position increment for one step of the latched mode and direction.
   function automatic logic signed [POS_W-1:0] step_delta(input logic up, input logic half);
      logic signed [POS_W-1:0] mag;
      mag = half ? POS_W'(1) : POS_W'(2);
      return up ? mag : -mag;
   endfunction

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state     <= IDLE;
         period_q  <= DIV_W'(1);
         div_q     <= '0;
         settle_q  <= '0;
         steps_q   <= '0;
         pos_q     <= '0;
         enable_q  <= 1'b0;
         up_q      <= 1'b1;
         half_q    <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         aborted_q <= 1'b0;
      end else begin
         state     <= state_nx;
         period_q  <= period_nx;
         div_q     <= div_nx;
         settle_q  <= settle_nx;
         steps_q   <= steps_nx;
         pos_q     <= pos_nx;
         enable_q  <= enable_nx;
         up_q      <= up_nx;
         half_q    <= half_nx;
         busy_q    <= busy_nx;
         done_q    <= done_nx;
         aborted_q <= aborted_nx;
      end
   end

   always_comb begin
      state_nx   = state;
      period_nx  = period_q;
      div_nx     = div_q;
      settle_nx  = settle_q;
      steps_nx   = steps_q;
      pos_nx     = pos_q;
      up_nx      = up_q;
      half_nx    = half_q;
      busy_nx    = busy_q;
      enable_nx  = 1'b0;
      done_nx    = 1'b0;
      aborted_nx = 1'b0;
      case (state)
         IDLE: begin
            // ABORT in IDLE only suppresses a coincident START.
            if (START && !ABORT) begin
               steps_nx  = STEPS;
               period_nx = (PERIOD == '0) ? DIV_W'(1) : PERIOD;
               up_nx     = DIR;
               half_nx   = HALF;
               div_nx    = '0;
               if (STEPS != '0) begin
                  busy_nx  = 1'b1;
                  state_nx = RUN;
               end else begin
                  done_nx = 1'b1;
               end
            end
         end
         RUN: begin
            if (ABORT) begin
               state_nx   = IDLE;
               busy_nx    = 1'b0;
               aborted_nx = 1'b1;
            end else if (div_q == period_q - DIV_W'(1)) begin
               div_nx    = '0;
               enable_nx = 1'b1;
               steps_nx  = steps_q - CNT_W'(1);
               pos_nx    = pos_q + step_delta(up_q, half_q);
               if (steps_q == CNT_W'(1)) begin
                  state_nx  = SETTLE;
                  settle_nx = '0;
               end
            end else begin
               div_nx = div_q + DIV_W'(1);
            end
         end
         SETTLE: begin
            // ABORT takes priority even on the edge that would finish settling.
            if (ABORT) begin
               state_nx   = IDLE;
               busy_nx    = 1'b0;
               aborted_nx = 1'b1;
            end else if (settle_q == SET_W'(SETTLE_CYCLES - 1)) begin
               state_nx = IDLE;
               busy_nx  = 1'b0;
               done_nx  = 1'b1;
            end else begin
               settle_nx = settle_q + SET_W'(1);
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   assign ENABLE     = enable_q;
   assign UP_DOWN    = up_q;
   assign HALF_FULL  = half_q;
   assign BUSY       = busy_q;
   assign DONE       = done_q;
   assign ABORTED    = aborted_q;
   assign STEPS_LEFT = steps_q;
   assign POSITION   = pos_q;

endmodule

// File: tb/tb_motor_move_sequencer.sv
// Bench for motor_move_sequencer: directed scenarios plus randomized moves, all
// checked against a timeline model derived from the move parameters.
module tb_motor_move_sequencer;

   localparam int SETTLE = 4;

   logic        CLK = 1'b0;
   logic        RESET, START, ABORT, DIR, HALF;
   logic [15:0] STEPS, PERIOD;
   logic        ENABLE, UP_DOWN, HALF_FULL, BUSY, DONE, ABORTED;
   logic [15:0] STEPS_LEFT;
   logic [23:0] POSITION;

   logic [45:0] obs, expv;
   logic [23:0] exp_pos;
   int          n_cmp = 0;
   int          n_bad = 0;

   always #5 CLK = ~CLK;

   assign obs = {ENABLE, BUSY, DONE, ABORTED, UP_DOWN, HALF_FULL, STEPS_LEFT, POSITION};

   motor_move_sequencer #(
      .CNT_W(16), .DIV_W(16), .POS_W(24), .SETTLE_CYCLES(SETTLE)
   ) dut (
      .CLK(CLK), .RESET(RESET), .START(START), .ABORT(ABORT),
      .STEPS(STEPS), .DIR(DIR), .HALF(HALF), .PERIOD(PERIOD),
      .ENABLE(ENABLE), .UP_DOWN(UP_DOWN), .HALF_FULL(HALF_FULL), .BUSY(BUSY),
      .DONE(DONE), .ABORTED(ABORTED), .STEPS_LEFT(STEPS_LEFT), .POSITION(POSITION)
   );

   // Expected output vector k edges after the accepting edge E0 of a move.
   // Step n (1..s) lands on edge E0+n*p; DONE lands s*p+SETTLE edges after E0.
   function automatic logic [45:0] model(int k, int s, int p, logic [23:0] pos0, bit dir, bit half);
      int pn, n, d, fin;
      logic en, bsy, dn;
      pn  = (p == 0) ? 1 : p;
      d   = (half ? 1 : 2) * (dir ? 1 : -1);
      fin = s * pn + SETTLE;
      if (s == 0) begin
         n = 0; en = 1'b0; bsy = 1'b0; dn = (k == 0);
      end else begin
         n   = (k / pn < s) ? k / pn : s;
         en  = (k > 0) && (k % pn == 0) && (k / pn <= s);
         bsy = (k < fin);
         dn  = (k == fin);
      end
      return {en, bsy, dn, 1'b0, dir, half, 16'(s - n), pos0 + 24'(d * n)};
   endfunction

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic issue(int s, bit d, bit h, int p);
      STEPS = 16'(s); DIR = d; HALF = h; PERIOD = 16'(p); START = 1'b1;
      tick();
      START = 1'b0;
   endtask

   task automatic test_reset();
      RESET = 1'b1; START = 1'b0; ABORT = 1'b0; DIR = 1'b0; HALF = 1'b0;
      STEPS = 16'd7; PERIOD = 16'd3;
      tick(); tick();
      RESET = 1'b0;
      n_cmp++; if (ENABLE !== 1'b0) begin n_bad++; $display("FAIL reset_enable got=%b exp=0", ENABLE); end
      n_cmp++; if (BUSY !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", BUSY); end
      n_cmp++; if (DONE !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b exp=0", DONE); end
      n_cmp++; if (ABORTED !== 1'b0) begin n_bad++; $display("FAIL reset_aborted got=%b exp=0", ABORTED); end
      n_cmp++; if (UP_DOWN !== 1'b1) begin n_bad++; $display("FAIL reset_up_down got=%b exp=1", UP_DOWN); end
      n_cmp++; if (HALF_FULL !== 1'b1) begin n_bad++; $display("FAIL reset_half_full got=%b exp=1", HALF_FULL); end
      n_cmp++; if (STEPS_LEFT !== 16'd0) begin n_bad++; $display("FAIL reset_steps_left got=%0d exp=0", STEPS_LEFT); end
      n_cmp++; if (POSITION !== 24'd0) begin n_bad++; $display("FAIL reset_position got=%h exp=0", POSITION); end
      exp_pos = 24'd0;
   endtask

   task automatic test_basic_up();
      logic [23:0] p0;
      int en_cnt;
      p0 = exp_pos; en_cnt = 0;
      issue(3, 1'b1, 1'b1, 4);
      for (int k = 0; k <= 3 * 4 + SETTLE + 2; k++) begin
         if (k > 0) tick();
         expv = model(k, 3, 4, p0, 1'b1, 1'b1);
         if (ENABLE === 1'b1) en_cnt++;
         n_cmp++;
         if (obs !== expv) begin n_bad++; $display("FAIL basic_up k=%0d got=%h exp=%h", k, obs, expv); end
      end
      n_cmp++; if (en_cnt != 3) begin n_bad++; $display("FAIL basic_up_enable_count got=%0d exp=3", en_cnt); end
      exp_pos = expv[23:0];
   endtask

   task automatic test_full_down();
      logic [23:0] p0;
      p0 = exp_pos;
      issue(2, 1'b0, 1'b0, 0);
      for (int k = 0; k <= 2 + SETTLE + 2; k++) begin
         if (k > 0) tick();
         expv = model(k, 2, 0, p0, 1'b0, 1'b0);
         n_cmp++;
         if (obs !== expv) begin n_bad++; $display("FAIL full_down k=%0d got=%h exp=%h", k, obs, expv); end
      end
      n_cmp++; if (POSITION !== 24'hFFFFFF) begin n_bad++; $display("FAIL full_down_wrap got=%h exp=ffffff", POSITION); end
      exp_pos = expv[23:0];
   endtask

   task automatic test_zero_len();
      logic [23:0] p0;
      p0 = exp_pos;
      issue(0, 1'b1, 1'b0, 5);
      for (int k = 0; k <= 3; k++) begin
         if (k > 0) tick();
         expv = model(k, 0, 5, p0, 1'b1, 1'b0);
         n_cmp++;
         if (obs !== expv) begin n_bad++; $display("FAIL zero_len k=%0d got=%h exp=%h", k, obs, expv); end
      end
      // ABORT in IDLE drops a coincident START: latched mode bits must not move.
      STEPS = 16'd5; DIR = 1'b0; HALF = 1'b1; PERIOD = 16'd1; START = 1'b1; ABORT = 1'b1;
      tick();
      START = 1'b0; ABORT = 1'b0;
      for (int k = 0; k < 3; k++) begin
         if (k > 0) tick();
         expv = {6'b000010, 16'd0, p0};
         n_cmp++;
         if (obs !== expv) begin n_bad++; $display("FAIL abort_idle k=%0d got=%h exp=%h", k, obs, expv); end
      end
   endtask

   task automatic test_abort();
      logic [23:0] p0;
      p0 = exp_pos;
      issue(10, 1'b1, 1'b1, 2);
      for (int k = 0; k <= 5; k++) begin
         if (k > 0) tick();
         expv = model(k, 10, 2, p0, 1'b1, 1'b1);
         n_cmp++;
         if (obs !== expv) begin n_bad++; $display("FAIL abort_run k=%0d got=%h exp=%h", k, obs, expv); end
      end
      ABORT = 1'b1;
      tick();
      ABORT = 1'b0;
      expv = {6'b000111, 16'd8, p0 + 24'd2};
      n_cmp++;
      if (obs !== expv) begin n_bad++; $display("FAIL abort_edge got=%h exp=%h", obs, expv); end
      p0 = p0 + 24'd2;
      issue(1, 1'b0, 1'b1, 1);
      for (int k = 0; k <= 1 + SETTLE + 1; k++) begin
         if (k > 0) tick();
         expv = model(k, 1, 1, p0, 1'b0, 1'b1);
         n_cmp++;
         if (obs !== expv) begin n_bad++; $display("FAIL abort_restart k=%0d got=%h exp=%h", k, obs, expv); end
      end
      exp_pos = expv[23:0];
   endtask

   task automatic test_midmove_ignore();
      logic [23:0] p0;
      p0 = exp_pos;
      issue(3, 1'b1, 1'b0, 3);
      for (int k = 0; k <= 3 * 3 + SETTLE + 2; k++) begin
         if (k > 0) tick();
         expv = model(k, 3, 3, p0, 1'b1, 1'b0);
         n_cmp++;
         if (obs !== expv) begin n_bad++; $display("FAIL midmove k=%0d got=%h exp=%h", k, obs, expv); end
         if (k == 2) begin
            START = 1'b1; STEPS = 16'd5; PERIOD = 16'd7; DIR = 1'b0; HALF = 1'b1;
         end
         if (k == 6) START = 1'b0;
      end
      exp_pos = expv[23:0];
   endtask

   task automatic test_back_to_back();
      logic [23:0] p0;
      p0 = exp_pos;
      issue(2, 1'b1, 1'b1, 2);
      for (int k = 0; k <= 2 * 2 + SETTLE; k++) begin
         if (k > 0) tick();
         expv = model(k, 2, 2, p0, 1'b1, 1'b1);
         n_cmp++;
         if (obs !== expv) begin n_bad++; $display("FAIL b2b_first k=%0d got=%h exp=%h", k, obs, expv); end
      end
      p0 = expv[23:0];
      issue(3, 1'b0, 1'b0, 1);
      for (int k = 0; k <= 3 + SETTLE + 1; k++) begin
         if (k > 0) tick();
         expv = model(k, 3, 1, p0, 1'b0, 1'b0);
         n_cmp++;
         if (obs !== expv) begin n_bad++; $display("FAIL b2b_second k=%0d got=%h exp=%h", k, obs, expv); end
      end
      exp_pos = expv[23:0];
   endtask

   task automatic test_random();
      int s, p, pn, fin, ka, n, dl, gap, last;
      bit d, h;
      logic [23:0] p0;
      for (int it = 0; it < 12; it++) begin
         s   = $urandom_range(0, 6);
         p   = $urandom_range(0, 4);
         d   = 1'($urandom_range(0, 1));
         h   = 1'($urandom_range(0, 1));
         gap = $urandom_range(0, 3);
         pn  = (p == 0) ? 1 : p;
         fin = s * pn + SETTLE;
         dl  = (h ? 1 : 2) * (d ? 1 : -1);
         ka  = (s != 0 && $urandom_range(0, 1) == 1) ? int'($urandom_range(1, fin)) : -1;
         last = (ka > 0) ? ka : fin + 1;
         repeat (gap) tick();
         p0 = exp_pos;
         issue(s, d, h, p);
         for (int k = 0; k <= last; k++) begin
            if (k > 0) begin
               if (k == ka) ABORT = 1'b1;
               tick();
               ABORT = 1'b0;
            end
            if (k == ka) begin
               n = (ka - 1) / pn;
               if (n > s) n = s;
               expv = {4'b0001, d, h, 16'(s - n), p0 + 24'(dl * n)};
            end else begin
               expv = model(k, s, p, p0, d, h);
            end
            n_cmp++;
            if (obs !== expv) begin
               n_bad++;
               $display("FAIL random it=%0d s=%0d p=%0d abort_k=%0d k=%0d got=%h exp=%h", it, s, p, ka, k, obs, expv);
            end
         end
         exp_pos = expv[23:0];
      end
   endtask

   task automatic test_reset_midmove();
      logic [23:0] p0;
      p0 = exp_pos;
      issue(6, 1'b0, 1'b1, 3);
      for (int k = 0; k <= 4; k++) begin
         if (k > 0) tick();
         expv = model(k, 6, 3, p0, 1'b0, 1'b1);
         n_cmp++;
         if (obs !== expv) begin n_bad++; $display("FAIL reset_mid_run k=%0d got=%h exp=%h", k, obs, expv); end
      end
      RESET = 1'b1;
      tick();
      RESET = 1'b0;
      for (int k = 0; k < 6; k++) begin
         if (k > 0) tick();
         expv = {6'b000011, 16'd0, 24'd0};
         n_cmp++;
         if (obs !== expv) begin n_bad++; $display("FAIL reset_mid k=%0d got=%h exp=%h", k, obs, expv); end
      end
      exp_pos = 24'd0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_basic_up();
      test_full_down();
      test_zero_len();
      test_abort();
      test_midmove_ignore();
      test_back_to_back();
      test_random();
      test_reset_midmove();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/motor_move_sequencer.md
Name: motor_move_sequencer

Overview:
- Sequences the stepper motor controller for complete moves.
- Accepts one move command: step count, direction, step mode and step period. Emits one-cycle ENABLE strobes at the programmed rate and drives UP_DOWN / HALF_FULL, which stay stable for the whole move.
- Tracks absolute position in half-step units and reports completion or abort through pulses.
- Sits between the host/command logic and the motor controller, which advances one state per ENABLE-high clock edge.

Parameters:
- CNT_W, 16, width of step count and remaining-step counter.
- DIV_W, 16, width of step period (clock cycles per step).
- POS_W, 24, width of the two's-complement position counter, in half-step units.
- SETTLE_CYCLES, 4, idle cycles after the last step before DONE is asserted.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  synchronous, active-high reset.
- START  in  1  move request; sampled in IDLE only.
- ABORT  in  1  stop the current move.
- STEPS  in  CNT_W  number of steps to issue.
- DIR  in  1  1 = up (+), 0 = down (-).
- HALF  in  1  1 = half step (+/-1), 0 = full step (+/-2).
- PERIOD  in  DIV_W  cycles between steps; 0 is treated as 1.
- ENABLE  out  1  one-cycle step strobe to the motor controller.
- UP_DOWN  out  1  latched DIR.
- HALF_FULL  out  1  latched HALF.
- BUSY  out  1  move in progress.
- DONE  out  1  one-cycle pulse, move completed.
- ABORTED  out  1  one-cycle pulse, move aborted.
- STEPS_LEFT  out  CNT_W  remaining steps.
- POSITION  out  POS_W  signed absolute position, half-step units.

Behaviour:
- Reset (RESET high at edge):
  - State IDLE.
  - ENABLE, BUSY, DONE, ABORTED = 0.
  - UP_DOWN = 1, HALF_FULL = 1.
  - STEPS_LEFT = 0, POSITION = 0, divider = 0, settle counter = 0.
  - RESET overrides everything, including mid-move.
- All outputs are registered.
- States: IDLE, RUN, SETTLE.
- IDLE, START = 1 and ABORT = 0 at edge E0:
  - Latch STEPS into STEPS_LEFT; latch PERIOD (0 becomes 1).
  - UP_DOWN <= DIR, HALF_FULL <= HALF.
  - If STEPS != 0: BUSY <= 1, divider <= 0, next state RUN.
  - If STEPS == 0: DONE <= 1 at E0; BUSY stays 0; no ENABLE; remain IDLE.
- RUN:
  - Divider increments each edge.
  - At the edge where divider == PERIOD-1:
    - divider <= 0, ENABLE <= 1, STEPS_LEFT <= STEPS_LEFT-1.
    - POSITION <= POSITION +/- (HALF_FULL ? 1 : 2); the sign follows UP_DOWN.
  - Otherwise ENABLE <= 0.
  - Resulting timing: ENABLE is high in the cycle after edges E0+n*PERIOD, n = 1..STEPS. With PERIOD = 1, ENABLE stays high for STEPS consecutive cycles.
  - When STEPS_LEFT reaches 0: next state SETTLE, settle counter <= 0.
- SETTLE:
  - ENABLE = 0; counter increments.
  - At the edge the counter reaches SETTLE_CYCLES-1: BUSY <= 0, DONE <= 1, state IDLE.
  - Result: the last ENABLE cycle and DONE are separated by SETTLE_CYCLES cycles.
- DONE and ABORTED: high for exactly one cycle.
- START sampled in the DONE-high cycle is accepted normally, so back-to-back moves are allowed.
- START while BUSY: ignored. STEPS/DIR/HALF/PERIOD changes mid-move: ignored.
- ABORT in RUN or SETTLE, at the next edge:
  - State IDLE, BUSY <= 0, ABORTED <= 1, ENABLE <= 0.
  - DONE is not asserted.
  - STEPS_LEFT holds the remaining count.
  - ABORT wins over a coincident step edge: no ENABLE, no STEPS_LEFT or POSITION change.
- ABORT in IDLE: no effect except that it blocks a coincident START, which is dropped.
- POSITION wraps modulo 2^POS_W (e.g. 0 minus 1 gives all ones). It is never cleared except by RESET.
- UP_DOWN / HALF_FULL hold their last latched values while IDLE.

Test Plan:
1. Basic up move: after reset, START with STEPS=3, DIR=1, HALF=1, PERIOD=4.
   -> ENABLE high in cycles E0+4, +8, +12.
   -> POSITION 1, 2, 3; STEPS_LEFT 2, 1, 0.
   -> DONE single pulse 4 cycles after the last ENABLE; BUSY low the same cycle.
2. Full-step down move from POSITION=3: STEPS=2, DIR=0, HALF=0, PERIOD=0.
   -> UP_DOWN=0, HALF_FULL=0.
   -> Two consecutive ENABLE cycles; POSITION 1 then -1 (0xFFFFFF).
3. Zero-length move: STEPS=0.
   -> DONE one cycle after START; BUSY never high; no ENABLE; POSITION unchanged.
4. Abort on a step edge: STEPS=10, PERIOD=2, ABORT coincident with the 3rd step edge.
   -> Exactly 2 ENABLE pulses; ABORTED pulse.
   -> STEPS_LEFT=8, POSITION=+2; no DONE; a new START is accepted in the next cycle.
5. Mid-move command changes: START with STEPS=5 while BUSY, plus PERIOD changed mid-move.
   -> Ignored; the original move completes with its original STEPS and spacing.
6. Reset mid-move: RESET high during RUN.
   -> At the next edge all outputs take reset values (POSITION=0, UP_DOWN=1); no further ENABLE; no DONE.
